fsm_ring: RTL
=============

# fsm_ring

Parametrised ring sequencer: the N-state successor of the fixed three-state code-steering FSM. It holds its own current-state index, advances one state per enabled cycle when that state's advance condition is true, and drives the runtime-programmable code of the current state. It adds three features: a wrap/terminal-hold mode, a per-state dwell counter, and a programmable timeout that forces a return to state 0. It sits in the FSM test fabric as a drop-in control sequencer.

## Interface
- N, 4, number of states (2..16)
- W, 2, state-code width; W >= clog2(N) not required (codes are free-form)
- CW, 8, dwell/timeout counter width (2..16)
- IW, derived = max(1, clog2(N)), index width
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- en  in  1  cycle enable; low freezes all state
- i  in  N  advance condition; bit k applies while in state k
- codes  in  N*W  state codes, state k at bits [k*W +: W]; may change any cycle
- wrap  in  1  1: state N-1 advances to 0; 0: state N-1 is terminal (holds)
- tmo  in  CW  timeout in enabled cycles; 0 disables timeout
- y  out  W  codes[idx*W +: W], combinational from the registered idx
- idx  out  IW  current state index, registered
- adv  out  1  registered pulse: a state advance occurred on the last edge
- tout  out  1  registered pulse: a timeout occurred on the last edge
- dwell  out  CW  enabled cycles spent in the current state, registered

## Operation
- Reset (on a clock edge with reset=1; reset overrides en): idx=0, dwell=0, adv=0, tout=0; y=codes[0 +: W].
- en=0: idx and dwell hold; adv=0 and tout=0 on that edge.
- en=1, with evaluation order fixed as follows:
  1. Advance: i[idx]=1 and (idx<N-1 or wrap=1) → idx<=(idx==N-1 ? 0 : idx+1), dwell<=0, adv<=1.
  2. Timeout: otherwise, if tmo!=0 and dwell==tmo-1 → idx<=0, dwell<=0, tout<=1.
  3. Otherwise: idx holds; dwell<=dwell+1, saturating at 2^CW-1; adv<=0, tout<=0.
- Terminal hold (wrap=0, idx=N-1, i[N-1]=1): this is not an advance. adv=0, dwell keeps counting, and the timeout still applies.
- Advance has priority over timeout when both qualify on the same edge.
- A timeout in state 0 keeps idx=0 but still clears dwell and pulses tout.
- adv and tout are never high in the same cycle.
- Changing tmo mid-dwell takes effect immediately. If the new tmo is <= dwell, the exact-match compare never fires until the next state change; this is intended.
- A change on wrap or codes takes effect on the next edge (wrap) or immediately on y (codes). No internal copy is kept.
- Index arithmetic is modulo N, not modulo 2^IW. idx never takes values >= N.

## Timing
- Latency: y, idx, dwell, adv and tout reflect a decision one cycle after the edge that samples en/i.
- adv and tout are one-cycle pulses per event and re-assert on consecutive edges if events repeat (e.g. i all-ones with wrap=1 → adv high every enabled cycle).
- Throughput: at most one state transition per enabled cycle.
- A timeout fires on the tmo-th consecutive enabled non-advancing cycle in a state. tmo=1 → it fires on the first such cycle.
- No combinational path from i/en to any output. y depends combinationally on codes only.

## Test plan
Unless noted: N=4, W=2, CW=8, codes=8'hB4 (c0=00, c1=01, c2=11, c3=10).
- **Reset and y mapping:** assert reset for 2 cycles with en=1 and i=4'hF → idx=0, y=2'b00, dwell=0, adv=0, tout=0. Release reset with tmo=0, wrap=1, i=4'hF, en=1 for 5 cycles → y sequence 01,11,10,00,01; adv high every cycle.
- **Terminal hold:** wrap=0, i=4'hF, tmo=0 → idx reaches 3 and holds; y=2'b10; adv drops to 0 after reaching 3; dwell counts 1,2,3…
- **Timeout:** tmo=5, i=4'b0001, wrap=1 → advance to idx=1; dwell counts 1..4; on the 5th non-advancing cycle idx=0, tout=1 for one cycle, dwell=0. The pattern then repeats every 6 cycles.
- **Priority and timeout in state 0:** in idx=1 with dwell=tmo-1, assert i[1]=1 → idx=2, adv=1, tout=0. Separately, tmo=3 with i=0 in idx=0 → tout pulses every 3 cycles and idx stays 0.
- **Enable freeze and saturation:** drop en for 10 cycles mid-sequence → idx and dwell unchanged, adv=tout=0. With CW=4, tmo=0, i=0 → dwell saturates at 15.
- **Reset mid-operation:** assert reset while idx=2 and tout is pending (dwell=tmo-1) → next cycle idx=0, dwell=0, tout=0, y=codes[0].

Source files
------------

// File: rtl/fsm_ring.sv
// fsm_ring: parametrised N-state ring sequencer.
//
// Holds a registered state index. On each enabled cycle it advances when the
// current state's advance condition is set. It drives the runtime-programmable
// code of the current state on y.
//
// State N-1 either wraps to state 0 or is terminal, as selected by wrap.
// A per-state dwell counter runs alongside the index. A programmable timeout
// forces a return to state 0 after tmo consecutive non-advancing enabled cycles.
//
// Parameters
//   N   number of states (2..16)
//   W   state-code width (codes are free-form)
//   CW  dwell/timeout counter width (2..16)
//   IW  index width, max(1, clog2(N))
//
// Ports
//   clock  in   single clock, all logic on posedge
//   reset  in   synchronous, active-high; overrides en
//   en     in   cycle enable; low freezes idx and dwell
//   i      in   advance conditions, bit k applies while in state k
//   codes  in   state codes, state k at bits [k*W +: W]
//   wrap   in   1: state N-1 advances to 0, 0: state N-1 holds
//   tmo    in   timeout in enabled cycles, 0 disables it
//   y      out  code of the current state (combinational from idx and codes)
//   idx    out  current state index
//   adv    out  pulse: an advance happened on the last edge
//   tout   out  pulse: a timeout happened on the last edge
//   dwell  out  enabled cycles spent in the current state (saturating)
module fsm_ring #(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int CW = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic [N-1:0]    i,
  input  logic [N*W-1:0]  codes,
  input  logic            wrap,
  input  logic [CW-1:0]   tmo,
  output logic [W-1:0]    y,
  output logic [IW-1:0]   idx,
  output logic            adv,
  output logic            tout,
  output logic [CW-1:0]   dwell
);

  localparam logic [IW-1:0] LAST   = IW'(N - 1);
  localparam logic [CW-1:0] DW_MAX = '1;

  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic          adv_q, adv_d;
  logic          tout_q, tout_d;
  logic          adv_cond;
  logic          tmo_hit;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == DW_MAX) ? v : v + CW'(1);
  endfunction

  // Successor modulo N rather than modulo 2^IW, so idx never leaves 0..N-1.
  function automatic logic [IW-1:0] ring_next(input logic [IW-1:0] v);
    return (v == LAST) ? '0 : v + IW'(1);
  endfunction

  // A set condition on the terminal state with wrap=0 is a hold, not an advance.
  assign adv_cond = i[idx_q] && ((idx_q != LAST) || wrap);

  // Exact match only: lowering tmo below the current dwell leaves it unfired
  // until the next state change.
  assign tmo_hit  = (tmo != '0) && (dwell_q == tmo - CW'(1));

  always_comb begin
    idx_d   = idx_q;
    dwell_d = dwell_q;
    adv_d   = 1'b0;
    tout_d  = 1'b0;
    if (en) begin
      if (adv_cond) begin
        idx_d   = ring_next(idx_q);
        dwell_d = '0;
        adv_d   = 1'b1;
      end else if (tmo_hit) begin
        idx_d   = '0;
        dwell_d = '0;
        tout_d  = 1'b1;
      end else begin
        dwell_d = sat_inc(dwell_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q   <= '0;
      dwell_q <= '0;
      adv_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      adv_q   <= adv_d;
      tout_q  <= tout_d;
    end
  end

  assign y     = codes[int'(idx_q) * W +: W];
  assign idx   = idx_q;
  assign adv   = adv_q;
  assign tout  = tout_q;
  assign dwell = dwell_q;

endmodule
